// File: rtl/cpu_thermal_ctrl_pkg.sv
// Shared definitions for the CPU overheat shutdown controller.
package thermal_pkg;

    typedef enum logic [2:0] {
        ST_RUN          = 3'd0,
        ST_SHUTDOWN     = 3'd1,
        ST_WAIT_RESTART = 3'd2,
        ST_LOCKOUT      = 3'd3
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_COOLDOWN_CYCLES = 16;
    localparam int unsigned DEF_MAX_TRIPS       = 3;

endpackage

// File: rtl/cpu_thermal_ctrl_if.sv
// Sensor/sequencer-facing signal bundle of the thermal controller.
interface cpu_thermal_ctrl_if #(
    parameter int unsigned MAX_TRIPS = thermal_pkg::DEF_MAX_TRIPS
);
    localparam int unsigned TW = $clog2(MAX_TRIPS + 1);

    logic          cpu_overheated;
    logic          cpu_warm;
    logic          restart_req;
    logic          restart_ack;
    logic          shut_off_computer;
    logic          fan_on;
    logic          locked_out;
    logic [TW-1:0] trip_count;

    modport master (
        output cpu_overheated, cpu_warm, restart_req,
        input  restart_ack, shut_off_computer, fan_on, locked_out, trip_count
    );

    modport slave (
        input  cpu_overheated, cpu_warm, restart_req,
        output restart_ack, shut_off_computer, fan_on, locked_out, trip_count
    );

endinterface

// File: rtl/cpu_thermal_ctrl_sat_counter.sv
// Clearable, enabled up-counter that saturates at TERMINAL and flags it.
module sat_counter #(
    parameter int unsigned TERMINAL = 1
) (
    input  logic clk,
    input  logic areset_n,
    input  logic clr,
    input  logic en,
    output logic at_term_c
);
    localparam int unsigned W = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != W'(TERMINAL))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_term_c = (cnt == W'(TERMINAL));

endmodule

// File: rtl/cpu_thermal_ctrl.sv
// Overheat shutdown sequencer: debounce, cooldown, restart handshake, trip lockout.
module cpu_thermal_ctrl
    import thermal_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int unsigned MAX_TRIPS       = DEF_MAX_TRIPS
) (
    input  logic               clk,
    input  logic               areset_n,
    cpu_thermal_ctrl_if.slave  bus
);
    localparam int unsigned TW = $clog2(MAX_TRIPS + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] trip_q, trip_d;
    logic          ack_q, ack_d;
    logic          shut_q, shut_d;
    logic          fan_q, fan_d;
    logic          lock_q, lock_d;

    logic deb_term, cool_term;
    logic trip_fire, cool_done;
    logic deb_clr, cool_clr;

    assign trip_fire = (state_q == ST_RUN) && bus.cpu_overheated && deb_term;
    assign cool_done = (state_q == ST_SHUTDOWN) && !bus.cpu_overheated && cool_term;
    assign deb_clr   = (state_q != ST_RUN) || !bus.cpu_overheated || trip_fire;
    assign cool_clr  = (state_q != ST_SHUTDOWN) || bus.cpu_overheated || cool_done;

    sat_counter #(.TERMINAL(DEBOUNCE_CYCLES - 1)) u_deb (
        .clk       (clk),
        .areset_n  (areset_n),
        .clr       (deb_clr),
        .en        (bus.cpu_overheated),
        .at_term_c (deb_term)
    );

    sat_counter #(.TERMINAL(COOLDOWN_CYCLES - 1)) u_cool (
        .clk       (clk),
        .areset_n  (areset_n),
        .clr       (cool_clr),
        .en        (!bus.cpu_overheated),
        .at_term_c (cool_term)
    );

    // Next-state, trip accounting and next-output decode.
    always_comb begin
        state_d = state_q;
        trip_d  = trip_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (trip_fire) begin
                    state_d = ST_SHUTDOWN;
                    if (trip_q != TW'(MAX_TRIPS)) trip_d = trip_q + 1'b1;
                end
            end
            ST_SHUTDOWN: begin
                if (cool_done) begin
                    state_d = (trip_q == TW'(MAX_TRIPS)) ? ST_LOCKOUT : ST_WAIT_RESTART;
                end
            end
            ST_WAIT_RESTART: begin
                if (bus.cpu_overheated) begin
                    state_d = ST_SHUTDOWN;
                end else if (bus.restart_req) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b1;
                end
            end
            ST_LOCKOUT: state_d = ST_LOCKOUT;
            default:    state_d = ST_RUN;
        endcase

        // Outputs follow the state being entered so the registers mirror state_q.
        shut_d = (state_d != ST_RUN);
        fan_d  = (state_d == ST_RUN) ? bus.cpu_warm
                                     : ((state_d == ST_SHUTDOWN) || (state_d == ST_LOCKOUT));
        lock_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_RUN;
            trip_q  <= '0;
            ack_q   <= 1'b0;
            shut_q  <= 1'b0;
            fan_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trip_q  <= trip_d;
            ack_q   <= ack_d;
            shut_q  <= shut_d;
            fan_q   <= fan_d;
            lock_q  <= lock_d;
        end
    end

    assign bus.restart_ack       = ack_q;
    assign bus.shut_off_computer = shut_q;
    assign bus.fan_on            = fan_q;
    assign bus.locked_out        = lock_q;
    assign bus.trip_count        = trip_q;

endmodule

// File: tb/tb_cpu_thermal_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_cpu_thermal_ctrl;
    localparam int D = 4;
    localparam int C = 16;
    localparam int M = 3;

    localparam int RUN = 0;
    localparam int SD  = 1;
    localparam int WR  = 2;
    localparam int LK  = 3;

    logic clk = 1'b0;
    logic areset_n;
    always #5 clk = ~clk;

    cpu_thermal_ctrl_if #(.MAX_TRIPS(M)) bus();

    cpu_thermal_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .COOLDOWN_CYCLES(C),
        .MAX_TRIPS      (M)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: consecutive-sample counting over abstract modes.
    int m_mode, hi_run, lo_run, m_trips;
    bit m_ack, m_fan;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = RUN;
        hi_run  = 0;
        lo_run  = 0;
        m_trips = 0;
        m_ack   = 1'b0;
        m_fan   = 1'b0;
    endtask

    task automatic model_step(input bit oh, input bit warm, input bit req);
        m_ack = 1'b0;
        case (m_mode)
            RUN: begin
                if (oh) begin
                    hi_run++;
                    if (hi_run == D) begin
                        m_mode = SD;
                        hi_run = 0;
                        if (m_trips < M) m_trips++;
                    end
                end else begin
                    hi_run = 0;
                end
            end
            SD: begin
                if (oh) begin
                    lo_run = 0;
                end else begin
                    lo_run++;
                    if (lo_run == C) begin
                        lo_run = 0;
                        m_mode = (m_trips == M) ? LK : WR;
                    end
                end
            end
            WR: begin
                if (oh) begin
                    m_mode = SD;
                end else if (req) begin
                    m_mode = RUN;
                    m_ack  = 1'b1;
                end
            end
            default: ;
        endcase
        m_fan = (m_mode == RUN) ? warm : (m_mode != WR);
    endtask

    task automatic check_outputs();
        check_eq("shut_off", 32'(bus.shut_off_computer), 32'(m_mode != RUN));
        check_eq("fan_on",   32'(bus.fan_on),            32'(m_fan));
        check_eq("locked",   32'(bus.locked_out),        32'(m_mode == LK));
        check_eq("ack",      32'(bus.restart_ack),       32'(m_ack));
        check_eq("trips",    32'(bus.trip_count),        32'(m_trips));
    endtask

    task automatic step(input bit oh, input bit warm, input bit req);
        bus.cpu_overheated = oh;
        bus.cpu_warm       = warm;
        bus.restart_req    = req;
        @(posedge clk);
        model_step(oh, warm, req);
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n, input bit oh, input bit req);
        for (int i = 0; i < n; i++) step(oh, 1'($urandom_range(0, 1)), req);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2 areset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        areset_n = 1'b1;
    endtask

    initial begin
        int p;
        areset_n           = 1'b0;
        bus.cpu_overheated = 1'b0;
        bus.cpu_warm       = 1'b0;
        bus.restart_req    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        areset_n = 1'b1;

        // Short burst below debounce threshold.
        steps(D - 1, 1'b1, 1'b0);
        steps(3, 1'b0, 1'b0);
        steps(D - 1, 1'b1, 1'b0);
        steps(2, 1'b0, 1'b0);

        // Full trip, cooldown, restart handshake.
        steps(D, 1'b1, 1'b0);
        check_eq("t2_trip1", 32'(bus.trip_count), 32'd1);
        steps(C, 1'b0, 1'b0);
        steps(1, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);

        // Cooldown interrupted by a spike.
        steps(D, 1'b1, 1'b0);
        steps(10, 1'b0, 1'b0);
        steps(1, 1'b1, 1'b0);
        steps(C - 1, 1'b0, 1'b0);
        check_eq("t3_still_sd", 32'(bus.fan_on), 32'd1);
        steps(1, 1'b0, 1'b0);

        // Overheat beats restart in WAIT_RESTART.
        step(1'b1, 1'b0, 1'b1);
        check_eq("t4_trips", 32'(bus.trip_count), 32'd2);
        steps(C, 1'b0, 1'b1);
        steps(2, 1'b0, 1'b1);
        steps(2, 1'b0, 1'b0);

        // Third trip locks out; restart ignored.
        steps(D, 1'b1, 1'b1);
        steps(C, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        check_eq("t5_trips", 32'(bus.trip_count), 32'd3);
        check_eq("t5_locked", 32'(bus.locked_out), 32'd1);

        // Async reset from lockout, then a normal trip.
        async_reset();
        steps(D, 1'b1, 1'b0);
        check_eq("t6_trip", 32'(bus.trip_count), 32'd1);
        steps(C + 2, 1'b0, 1'b1);

        // Randomized traffic with varying overheat density.
        for (int blk = 0; blk < 24; blk++) begin
            case ($urandom_range(0, 2))
                0:       p = 5;
                1:       p = 35;
                default: p = 80;
            endcase
            for (int i = 0; i < 120; i++) begin
                step(($urandom_range(0, 99) < p), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30));
            end
            if ($urandom_range(0, 1) == 1) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
